// File: rtl/cmlk_stream_joiner_if.sv
// Lock-step AXI-Stream bundle for the stream joiner: NCH byte lanes sharing one handshake.
// Ready is replicated per channel so each upstream source sees its own bit.
interface cmlk_stream_joiner_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned DW  = 8
);
  logic [NCH*DW-1:0] tdata;
  logic [NCH-1:0]    tvalid;
  logic [NCH-1:0]    tlast;
  logic [NCH-1:0]    tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/cmlk_stream_joiner.sv
// Joins NCH AXIS lanes into one beat for the calc core, optionally packing frames into the DDR
// cache FIFO (CACHE/FLUSH) or unpacking them back out of it (REPLAY).
module cmlk_stream_joiner #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DW     = 8,
  parameter int unsigned FIFO_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [15:0]           replay_len,
  cmlk_stream_joiner_if.slave   s_axis,
  output logic [FIFO_W-1:0]     fifo_wrdata,
  output logic                  fifo_wren,
  input  logic                  fifo_full,
  input  logic [FIFO_W-1:0]     fifo_rddata,
  output logic                  fifo_rden,
  input  logic                  fifo_empty,
  output logic [NCH*DW-1:0]     j_data,
  output logic                  j_last,
  output logic                  j_vld,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  err_tlast
);

  localparam int unsigned BW    = NCH * DW;
  localparam int unsigned PACK  = FIFO_W / BW;
  localparam int unsigned SlotW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned CntW  = SlotW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StPass,
    StCache,
    StFlush,
    StReplay
  } state_e;

  state_e state_q;

  // Output registers
  logic [BW-1:0]     j_data_q;
  logic              j_vld_q;
  logic              j_last_q;
  logic [15:0]       frame_cnt_q;
  logic              err_q;

  // Pack side
  logic [SlotW-1:0]  slot_q;
  logic [FIFO_W-1:0] pack_q;
  logic [FIFO_W-1:0] word_q;
  logic              pend_q;
  logic [FIFO_W-1:0] pack_word;
  logic              word_done;

  // Unpack side
  logic [FIFO_W-1:0] unp_q;
  logic [FIFO_W-1:0] unp_d;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_d;
  logic              rd_pend_q;
  logic [15:0]       words_q;
  logic [15:0]       len_q;
  logic              emit;
  logic              emit_last;
  logic [BW-1:0]     emit_data;

  logic              all_vld;
  logic              space;
  logic              fire;
  logic              beat_last;
  logic              tl_bad;

  assign all_vld   = &s_axis.tvalid;
  assign beat_last = s_axis.tlast[0];
  assign tl_bad    = ~((&s_axis.tlast) | ~(|s_axis.tlast));

  // Backpressure only comes from a pending cache word that the FIFO cannot take.
  always_comb begin
    space = 1'b0;
    if (state_q == StPass) begin
      space = 1'b1;
    end else if (state_q == StCache) begin
      space = ~(pend_q & fifo_full);
    end
  end

  assign fire          = all_vld & space;
  assign s_axis.tready = {NCH{fire}};

  always_comb begin
    pack_word                   = pack_q;
    pack_word[slot_q*BW +: BW]  = s_axis.tdata;
  end

  assign word_done = fire & (state_q == StCache) & ((slot_q == SlotW'(PACK - 1)) | beat_last);
  assign fifo_wren   = pend_q & ~fifo_full;
  assign fifo_wrdata = word_q;

  // A word read last cycle is emitted straight from fifo_rddata so words stream back to back.
  always_comb begin
    emit      = 1'b0;
    emit_data = '0;
    unp_d     = unp_q;
    cnt_d     = cnt_q;
    if (rd_pend_q) begin
      emit      = 1'b1;
      emit_data = fifo_rddata[BW-1:0];
      unp_d     = fifo_rddata >> BW;
      cnt_d     = CntW'(PACK - 1);
    end else if (cnt_q != '0) begin
      emit      = 1'b1;
      emit_data = unp_q[BW-1:0];
      unp_d     = unp_q >> BW;
      cnt_d     = cnt_q - 1'b1;
    end
  end

  assign emit_last = emit & (cnt_d == '0) & (words_q == len_q);
  assign fifo_rden = (state_q == StReplay) & ~fifo_empty & (cnt_d == '0) & (words_q < len_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      j_data_q    <= '0;
      j_vld_q     <= 1'b0;
      j_last_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      slot_q      <= '0;
      pack_q      <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      unp_q       <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      words_q     <= '0;
      len_q       <= '0;
    end else begin
      j_vld_q  <= 1'b0;
      j_last_q <= 1'b0;

      if (fire) begin
        j_data_q <= s_axis.tdata;
        j_vld_q  <= 1'b1;
        j_last_q <= beat_last;
        if (tl_bad) begin
          err_q <= 1'b1;
        end
      end

      if (emit) begin
        j_data_q <= emit_data;
        j_vld_q  <= 1'b1;
        j_last_q <= emit_last;
      end

      // A word completing in the same cycle the old one drains keeps pend_q set.
      if (fifo_wren) begin
        pend_q <= 1'b0;
      end
      if (fire && state_q == StCache) begin
        if (word_done) begin
          word_q <= pack_word;
          pend_q <= 1'b1;
          pack_q <= '0;
          slot_q <= '0;
        end else begin
          pack_q <= pack_word;
          slot_q <= slot_q + 1'b1;
        end
      end

      unp_q     <= unp_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= fifo_rden;
      if (fifo_rden) begin
        words_q <= words_q + 16'd1;
      end

      unique case (state_q)
        StIdle: begin
          words_q <= '0;
          len_q   <= replay_len;
          unique case (mode)
            2'd0: state_q <= StPass;
            2'd1: state_q <= StCache;
            2'd2: if (replay_len != 16'd0) state_q <= StReplay;
            default: state_q <= StIdle;
          endcase
        end
        StPass: begin
          if (fire && beat_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= StIdle;
          end
        end
        StCache: begin
          if (fire && beat_last) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (fifo_wren) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= StIdle;
          end
        end
        StReplay: begin
          if (emit_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign j_data    = j_data_q;
  assign j_vld     = j_vld_q;
  assign j_last    = j_last_q;
  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_cnt_q;
  assign err_tlast = err_q;

endmodule

// File: tb/tb_cmlk_stream_joiner.sv
// Scoreboard bench for cmlk_stream_joiner (NCH=2, DW=8, FIFO_W=32, PACK=2) with a behavioural
// cache FIFO; expected beats/words are queued by stimulus and checked by a negedge monitor.
module tb_cmlk_stream_joiner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] replay_len;
  logic [31:0] fifo_wrdata;
  logic        fifo_wren;
  logic        fifo_full;
  logic [31:0] fifo_rddata;
  logic        fifo_rden;
  logic        fifo_empty;
  logic [15:0] j_data;
  logic        j_last;
  logic        j_vld;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_tlast;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] exp_j[$];
  logic [31:0] exp_w[$];
  logic [31:0] mem[$];
  int          mem_cnt = 0;
  logic        force_empty;

  always #5 clk = ~clk;

  cmlk_stream_joiner_if #(.NCH(2), .DW(8)) s_axis ();

  cmlk_stream_joiner #(
    .NCH   (2),
    .DW    (8),
    .FIFO_W(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .replay_len (replay_len),
    .s_axis     (s_axis),
    .fifo_wrdata(fifo_wrdata),
    .fifo_wren  (fifo_wren),
    .fifo_full  (fifo_full),
    .fifo_rddata(fifo_rddata),
    .fifo_rden  (fifo_rden),
    .fifo_empty (fifo_empty),
    .j_data     (j_data),
    .j_last     (j_last),
    .j_vld      (j_vld),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_tlast  (err_tlast)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Behavioural DDR cache FIFO: one-cycle read latency.
  always_comb fifo_empty = force_empty || (mem_cnt == 0);

  always @(posedge clk) begin
    if (fifo_rden && mem.size() > 0) fifo_rddata <= mem.pop_front();
    if (fifo_wren && !fifo_full) mem.push_back(fifo_wrdata);
    mem_cnt <= mem.size();
  end

  always @(negedge clk) begin
    if (j_vld) begin
      if (exp_j.size() == 0) begin
        flag("j_vld_unexpected");
      end else begin
        logic [16:0] e;
        e = exp_j.pop_front();
        check("j_data", {16'd0, j_data}, {16'd0, e[15:0]});
        check("j_last", {31'd0, j_last}, {31'd0, e[16]});
      end
    end
    if (fifo_wren) begin
      if (exp_w.size() == 0) begin
        flag("fifo_wren_unexpected");
      end else begin
        check("fifo_wrdata", fifo_wrdata, exp_w.pop_front());
      end
    end
    if (fifo_full) check("no_wren_while_full", {31'd0, fifo_wren}, 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic start(input logic [1:0] m, input logic [15:0] len);
    mode       = m;
    replay_len = len;
    tick(1);
    mode = 2'd3;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] tl);
    bit ok;
    exp_j.push_back({tl[0], b, a});
    s_axis.tdata  = {b, a};
    s_axis.tvalid = 2'b11;
    s_axis.tlast  = tl;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_axis.tready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("send_timeout");
    @(posedge clk);
    #1;
    s_axis.tvalid = 2'b00;
    s_axis.tlast  = 2'b00;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("idle_timeout");
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    mode          = 2'd3;
    replay_len    = 16'd0;
    fifo_full     = 1'b0;
    fifo_rddata   = '0;
    force_empty   = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tvalid = '0;
    s_axis.tlast  = '0;
    do_reset();

    check("rst_j_vld", {31'd0, j_vld}, 32'd0);
    check("rst_wren", {31'd0, fifo_wren}, 32'd0);
    check("rst_rden", {31'd0, fifo_rden}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_err", {31'd0, err_tlast}, 32'd0);
    check("rst_tready", {30'd0, s_axis.tready}, 32'd0);

    // PASS frame of four beats.
    start(2'd0, 16'd0);
    send(8'h01, 8'h10, 2'b00);
    send(8'h02, 8'h20, 2'b00);
    send(8'h03, 8'h30, 2'b00);
    send(8'h04, 8'h40, 2'b11);
    wait_idle();
    check("pass_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("pass_busy", {31'd0, busy}, 32'd0);

    // Channel 1 drops valid mid-frame: nothing may be consumed.
    start(2'd0, 16'd0);
    send(8'h05, 8'h50, 2'b00);
    s_axis.tdata  = {8'h00, 8'h06};
    s_axis.tvalid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gap_tready", {30'd0, s_axis.tready}, 32'd0);
    end
    tick(1);
    send(8'h06, 8'h60, 2'b11);
    wait_idle();
    check("gap_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    check("gap_err", {31'd0, err_tlast}, 32'd0);

    // Disagreeing tlast closes the frame on channel 0 and sets the sticky error.
    start(2'd0, 16'd0);
    send(8'h0a, 8'ha0, 2'b01);
    wait_idle();
    check("tlast_err_set", {31'd0, err_tlast}, 32'd1);
    check("tlast_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    start(2'd0, 16'd0);
    send(8'h0b, 8'hb0, 2'b11);
    wait_idle();
    check("tlast_err_sticky", {31'd0, err_tlast}, 32'd1);
    check("tlast_frame_cnt2", {16'd0, frame_cnt}, 32'd4);

    // Replay with zero length is a no-op.
    start(2'd2, 16'd0);
    check("replay0_busy", {31'd0, busy}, 32'd0);

    // CACHE five beats -> three packed words, last one zero padded.
    exp_w.push_back(32'h2212_2111);
    exp_w.push_back(32'h2414_2313);
    exp_w.push_back(32'h0000_2515);
    start(2'd1, 16'd0);
    for (int k = 0; k < 5; k++) begin
      send(8'h11 + 8'(k), 8'h21 + 8'(k), (k == 4) ? 2'b11 : 2'b00);
    end
    wait_idle();
    check("cache_frame_cnt", {16'd0, frame_cnt}, 32'd5);
    check("cache_words", mem_cnt, 32'd3);

    // REPLAY the three cached words with a two-cycle empty gap.
    exp_j.push_back({1'b0, 16'h2111});
    exp_j.push_back({1'b0, 16'h2212});
    exp_j.push_back({1'b0, 16'h2313});
    exp_j.push_back({1'b0, 16'h2414});
    exp_j.push_back({1'b0, 16'h2515});
    exp_j.push_back({1'b1, 16'h0000});
    start(2'd2, 16'd3);
    tick(3);
    force_empty = 1'b1;
    tick(2);
    force_empty = 1'b0;
    wait_idle();
    check("replay_frame_cnt", {16'd0, frame_cnt}, 32'd6);
    check("replay_drained", mem_cnt, 32'd0);

    // CACHE with the FIFO full for 10 cycles right after the first write.
    exp_w.push_back(32'h4232_4131);
    exp_w.push_back(32'h4434_4333);
    exp_w.push_back(32'h4636_4535);
    start(2'd1, 16'd0);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          send(8'h31 + 8'(k), 8'h41 + 8'(k), (k == 5) ? 2'b11 : 2'b00);
        end
      end
      begin
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (fifo_wren) begin
            ok = 1'b1;
            break;
          end
        end
        if (!ok) flag("full_first_write_timeout");
        tick(1);
        fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i == 9) check("full_tready", {30'd0, s_axis.tready}, 32'd0);
        end
        tick(1);
        fifo_full = 1'b0;
      end
    join
    wait_idle();
    check("full_frame_cnt", {16'd0, frame_cnt}, 32'd7);

    // Reset mid-frame: partial word dropped, error and counters cleared.
    start(2'd1, 16'd0);
    send(8'h77, 8'h88, 2'b00);
    do_reset();
    tick(5);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("midrst_err", {31'd0, err_tlast}, 32'd0);

    check("exp_j_drained", exp_j.size(), 32'd0);
    check("exp_w_drained", exp_w.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
